// File: rtl/id_ex_stage_register.sv
// ---------------------------------------------------------------------------
// id_ex_stage_register
// ID/EX pipeline boundary of the RISC-V core, directly downstream of
// main_controller. Latches the control bundle, decoded operands and register
// addresses into EX, detects load-use hazards against the instruction in EX,
// freezes the front end, applies branch flushes / downstream holds and counts
// load-use stall cycles.
//
// Ports
//   clk, rst               core clock; synchronous active-high reset
//   id_*                   control/data/address bundle from ID
//   ex_flush               branch taken in EX: kill the ID instruction
//   ex_hold                downstream stall: freeze this stage
//   ex_*                   registered copy of the id_* bundle
//   ex_valid               EX holds a real instruction
//   hazard_mux_enable      comb; 1 = main_controller outputs zero controls
//   pc_write, if_id_write  comb; 0 = PC / IF-ID register hold
//   stall_count            saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage_register #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_memory_read,
    input  logic              id_memory_to_register,
    input  logic              id_memory_write,
    input  logic              id_alu_source,
    input  logic              id_register_write,
    input  logic [3:0]        id_alu_option,
    input  logic [1:0]        id_auipc_lui,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_b5,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_immediate,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              ex_branch,
    output logic              ex_memory_read,
    output logic              ex_memory_to_register,
    output logic              ex_memory_write,
    output logic              ex_alu_source,
    output logic              ex_register_write,
    output logic [3:0]        ex_alu_option,
    output logic [1:0]        ex_auipc_lui,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7_b5,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_immediate,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_valid,
    output logic              hazard_mux_enable,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              branch;
        logic              memory_read;
        logic              memory_to_register;
        logic              memory_write;
        logic              alu_source;
        logic              register_write;
        logic [3:0]        alu_option;
        logic [1:0]        auipc_lui;
        logic [2:0]        funct3;
        logic              funct7_b5;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] immediate;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              valid;
    } stage_t;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_LOAD_USE = 2'd1,
        MODE_FLUSH    = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    stage_t             id_bundle_s;
    stage_t             stage_d;
    stage_t             stage_q;
    logic [CNT_W-1:0]   stall_count_d;
    logic [CNT_W-1:0]   stall_count_q;
    logic               load_use_s;
    mode_e              mode_s;

    // Gather the ID-side inputs into one bundle so NORMAL mode is a single copy.
    always_comb begin
        id_bundle_s                    = '0;
        id_bundle_s.branch             = id_branch;
        id_bundle_s.memory_read        = id_memory_read;
        id_bundle_s.memory_to_register = id_memory_to_register;
        id_bundle_s.memory_write       = id_memory_write;
        id_bundle_s.alu_source         = id_alu_source;
        id_bundle_s.register_write     = id_register_write;
        id_bundle_s.alu_option         = id_alu_option;
        id_bundle_s.auipc_lui          = id_auipc_lui;
        id_bundle_s.funct3             = id_funct3;
        id_bundle_s.funct7_b5          = id_funct7_b5;
        id_bundle_s.pc                 = id_pc;
        id_bundle_s.rs1_data           = id_rs1_data;
        id_bundle_s.rs2_data           = id_rs2_data;
        id_bundle_s.immediate          = id_immediate;
        id_bundle_s.rs1_addr           = id_rs1_addr;
        id_bundle_s.rs2_addr           = id_rs2_addr;
        id_bundle_s.rd_addr            = id_rd_addr;
        id_bundle_s.valid              = id_valid;
    end

    // Hazard detection and per-cycle priority decode (hold > flush > load-use).
    // Both source fields are compared whatever the instruction format, which
    // can only add a spurious stall, never miss a real one.
    always_comb begin
        load_use_s = stage_q.valid & stage_q.memory_read
                   & (stage_q.rd_addr != 5'd0) & id_valid
                   & ((stage_q.rd_addr == id_rs1_addr) | (stage_q.rd_addr == id_rs2_addr));
        if (ex_hold) begin
            mode_s = MODE_HOLD;
        end else if (ex_flush) begin
            mode_s = MODE_FLUSH;
        end else if (load_use_s) begin
            mode_s = MODE_LOAD_USE;
        end else begin
            mode_s = MODE_NORMAL;
        end
    end

    // Next-state and front-end control; reset forces the free-running defaults.
    always_comb begin
        stage_d           = stage_q;
        stall_count_d     = stall_count_q;
        hazard_mux_enable = 1'b0;
        pc_write          = 1'b1;
        if_id_write       = 1'b1;
        if (rst) begin
            stage_d       = '0;
            stall_count_d = '0;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                MODE_FLUSH: begin
                    // Bubble; the branch target loads into IF/ID this cycle.
                    stage_d = '0;
                end
                MODE_LOAD_USE: begin
                    // Bubble for one cycle; the load leaves EX so the stall self-clears.
                    stage_d           = '0;
                    hazard_mux_enable = 1'b1;
                    pc_write          = 1'b0;
                    if_id_write       = 1'b0;
                    if (stall_count_q != {CNT_W{1'b1}}) begin
                        stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        stall_count_d = stall_count_q;
                    end
                end
                MODE_NORMAL: begin
                    stage_d = id_bundle_s;
                end
                default: begin
                    stage_d = '0;
                end
            endcase
        end
    end

    // Stage and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q       <= '0;
            stall_count_q <= '0;
        end else begin
            stage_q       <= stage_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_branch             = stage_q.branch;
    assign ex_memory_read        = stage_q.memory_read;
    assign ex_memory_to_register = stage_q.memory_to_register;
    assign ex_memory_write       = stage_q.memory_write;
    assign ex_alu_source         = stage_q.alu_source;
    assign ex_register_write     = stage_q.register_write;
    assign ex_alu_option         = stage_q.alu_option;
    assign ex_auipc_lui          = stage_q.auipc_lui;
    assign ex_funct3             = stage_q.funct3;
    assign ex_funct7_b5          = stage_q.funct7_b5;
    assign ex_pc                 = stage_q.pc;
    assign ex_rs1_data           = stage_q.rs1_data;
    assign ex_rs2_data           = stage_q.rs2_data;
    assign ex_immediate          = stage_q.immediate;
    assign ex_rs1_addr           = stage_q.rs1_addr;
    assign ex_rs2_addr           = stage_q.rs2_addr;
    assign ex_rd_addr            = stage_q.rd_addr;
    assign ex_valid              = stage_q.valid;
    assign stall_count           = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_register
// Directed-vector bench for id_ex_stage_register. A second instance with a
// 2-bit stall counter shares the inputs and is used for saturation checks.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_register;

    logic        clk;
    logic        rst;
    logic        id_valid, id_branch, id_memory_read, id_memory_to_register;
    logic        id_memory_write, id_alu_source, id_register_write;
    logic [3:0]  id_alu_option;
    logic [1:0]  id_auipc_lui;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_immediate;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        ex_flush, ex_hold;

    logic        ex_branch, ex_memory_read, ex_memory_to_register, ex_memory_write;
    logic        ex_alu_source, ex_register_write;
    logic [3:0]  ex_alu_option;
    logic [1:0]  ex_auipc_lui;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_b5;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic        ex_valid, hazard_mux_enable, pc_write, if_id_write;
    logic [15:0] stall_count;

    logic        s_branch, s_memory_read, s_memory_to_register, s_memory_write;
    logic        s_alu_source, s_register_write;
    logic [3:0]  s_alu_option;
    logic [1:0]  s_auipc_lui;
    logic [2:0]  s_funct3;
    logic        s_funct7_b5;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_immediate;
    logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
    logic        s_valid, s_hazard_mux_enable, s_pc_write, s_if_id_write;
    logic [1:0]  s_stall_count;

    int tests_run;
    int tests_failed;

    id_ex_stage_register #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_memory_read(id_memory_read), .id_memory_to_register(id_memory_to_register),
        .id_memory_write(id_memory_write), .id_alu_source(id_alu_source),
        .id_register_write(id_register_write), .id_alu_option(id_alu_option),
        .id_auipc_lui(id_auipc_lui), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_immediate(id_immediate), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_branch(ex_branch), .ex_memory_read(ex_memory_read),
        .ex_memory_to_register(ex_memory_to_register), .ex_memory_write(ex_memory_write),
        .ex_alu_source(ex_alu_source), .ex_register_write(ex_register_write),
        .ex_alu_option(ex_alu_option), .ex_auipc_lui(ex_auipc_lui), .ex_funct3(ex_funct3),
        .ex_funct7_b5(ex_funct7_b5), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_immediate), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_valid(ex_valid),
        .hazard_mux_enable(hazard_mux_enable), .pc_write(pc_write),
        .if_id_write(if_id_write), .stall_count(stall_count)
    );

    id_ex_stage_register #(.DATA_W(32), .ADDR_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch),
        .id_memory_read(id_memory_read), .id_memory_to_register(id_memory_to_register),
        .id_memory_write(id_memory_write), .id_alu_source(id_alu_source),
        .id_register_write(id_register_write), .id_alu_option(id_alu_option),
        .id_auipc_lui(id_auipc_lui), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_immediate(id_immediate), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_branch(s_branch), .ex_memory_read(s_memory_read),
        .ex_memory_to_register(s_memory_to_register), .ex_memory_write(s_memory_write),
        .ex_alu_source(s_alu_source), .ex_register_write(s_register_write),
        .ex_alu_option(s_alu_option), .ex_auipc_lui(s_auipc_lui), .ex_funct3(s_funct3),
        .ex_funct7_b5(s_funct7_b5), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
        .ex_rs2_data(s_rs2_data), .ex_immediate(s_immediate), .ex_rs1_addr(s_rs1_addr),
        .ex_rs2_addr(s_rs2_addr), .ex_rd_addr(s_rd_addr), .ex_valid(s_valid),
        .hazard_mux_enable(s_hazard_mux_enable), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .stall_count(s_stall_count)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and step away from it before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic id_clear();
        id_valid = 1'b0; id_branch = 1'b0; id_memory_read = 1'b0;
        id_memory_to_register = 1'b0; id_memory_write = 1'b0; id_alu_source = 1'b0;
        id_register_write = 1'b0; id_alu_option = 4'd0; id_auipc_lui = 2'd0;
        id_funct3 = 3'd0; id_funct7_b5 = 1'b0; id_pc = 32'd0; id_rs1_data = 32'd0;
        id_rs2_data = 32'd0; id_immediate = 32'd0; id_rs1_addr = 5'd0;
        id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    endtask

    task automatic id_random();
        id_valid = 1'b1; id_branch = 1'($urandom); id_memory_read = 1'b1;
        id_memory_to_register = 1'($urandom); id_memory_write = 1'($urandom);
        id_alu_source = 1'($urandom); id_register_write = 1'b1;
        id_alu_option = 4'($urandom); id_auipc_lui = 2'($urandom);
        id_funct3 = 3'($urandom); id_funct7_b5 = 1'($urandom);
        id_pc = 32'($urandom) | 32'h1; id_rs1_data = 32'($urandom);
        id_rs2_data = 32'($urandom); id_immediate = 32'($urandom);
        id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom);
        id_rd_addr = 5'($urandom_range(1, 31));
    endtask

    // lw rd, imm(rs1)
    task automatic id_load(input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [31:0] pc, input logic [31:0] imm);
        id_clear();
        id_valid = 1'b1; id_memory_read = 1'b1; id_memory_to_register = 1'b1;
        id_alu_source = 1'b1; id_register_write = 1'b1; id_funct3 = 3'd2;
        id_rd_addr = rd; id_rs1_addr = rs1; id_pc = pc; id_immediate = imm;
    endtask

    // add rd, rs1, rs2
    task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] pc);
        id_clear();
        id_valid = 1'b1; id_register_write = 1'b1;
        id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2; id_pc = pc;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        ex_flush = 1'b0;
        ex_hold = 1'b0;
        id_clear();

        // Reset for two edges with random ID contents and hold/flush asserted.
        rst = 1'b1;
        id_random();
        ex_hold = 1'b1;
        settle();
        check_eq("rst_pc_write", pc_write, 1);
        check_eq("rst_hazard", hazard_mux_enable, 0);
        tick();
        id_random();
        ex_hold = 1'b0;
        tick();
        check_eq("rst_ex_valid", ex_valid, 0);
        check_eq("rst_ex_memory_read", ex_memory_read, 0);
        check_eq("rst_ex_rd_addr", ex_rd_addr, 0);
        check_eq("rst_ex_pc", ex_pc, 0);
        check_eq("rst_ex_immediate", ex_immediate, 0);
        check_eq("rst_stall_count", stall_count, 0);
        check_eq("rst_if_id_write", if_id_write, 1);
        check_eq("rst_pc_write2", pc_write, 1);
        rst = 1'b0;

        // Pass-through: lw x5, 8(x2) at pc 0x40.
        id_load(5'd5, 5'd2, 32'h40, 32'd8);
        settle();
        check_eq("pass_hazard", hazard_mux_enable, 0);
        check_eq("pass_pc_write", pc_write, 1);
        tick();
        check_eq("pass_ex_memory_read", ex_memory_read, 1);
        check_eq("pass_ex_rd_addr", ex_rd_addr, 5);
        check_eq("pass_ex_immediate", ex_immediate, 8);
        check_eq("pass_ex_pc", ex_pc, 32'h40);
        check_eq("pass_ex_valid", ex_valid, 1);

        // Load-use: EX lw x5, ID add x6, x5, x7.
        id_add(5'd6, 5'd5, 5'd7, 32'h44);
        settle();
        check_eq("lu_hazard", hazard_mux_enable, 1);
        check_eq("lu_pc_write", pc_write, 0);
        check_eq("lu_if_id_write", if_id_write, 0);
        tick();
        check_eq("lu_bubble_valid", ex_valid, 0);
        check_eq("lu_bubble_regwr", ex_register_write, 0);
        check_eq("lu_stall_count", stall_count, 1);
        check_eq("lu_release_hazard", hazard_mux_enable, 0);
        check_eq("lu_release_pc_write", pc_write, 1);
        tick();
        check_eq("lu_add_valid", ex_valid, 1);
        check_eq("lu_add_rd", ex_rd_addr, 6);
        check_eq("lu_add_rs1", ex_rs1_addr, 5);
        check_eq("lu_add_pc", ex_pc, 32'h44);
        check_eq("lu_add_stall_count", stall_count, 1);

        // x0 destination: EX lw x0, ID add x8, x0, x0.
        id_load(5'd0, 5'd1, 32'h48, 32'd0);
        tick();
        id_add(5'd8, 5'd0, 5'd0, 32'h4C);
        settle();
        check_eq("x0_hazard", hazard_mux_enable, 0);
        // Non-load producer: EX add x5, ID add x9, x5, x5.
        id_add(5'd5, 5'd1, 5'd2, 32'h50);
        tick();
        id_add(5'd9, 5'd5, 5'd5, 32'h54);
        settle();
        check_eq("noload_hazard", hazard_mux_enable, 0);
        check_eq("noload_pc_write", pc_write, 1);

        // Flush beats load-use: EX lw x5, ID add x6, x5 with ex_flush.
        id_load(5'd5, 5'd3, 32'h58, 32'd4);
        tick();
        id_add(5'd6, 5'd5, 5'd0, 32'h5C);
        ex_flush = 1'b1;
        settle();
        check_eq("flush_hazard", hazard_mux_enable, 0);
        check_eq("flush_pc_write", pc_write, 1);
        check_eq("flush_if_id_write", if_id_write, 1);
        tick();
        ex_flush = 1'b0;
        check_eq("flush_ex_valid", ex_valid, 0);
        check_eq("flush_ex_regwr", ex_register_write, 0);
        check_eq("flush_ex_pc", ex_pc, 0);
        check_eq("flush_stall_count", stall_count, 1);

        // Hold: EX lw x9, then three held cycles while ID keeps changing.
        id_load(5'd9, 5'd4, 32'h80, 32'h10);
        tick();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_add(5'(10 + i), 5'd9, 5'(i), 32'(32'h100 + 4 * i));
            settle();
            check_eq("hold_pc_write", pc_write, 0);
            check_eq("hold_if_id_write", if_id_write, 0);
            check_eq("hold_hazard", hazard_mux_enable, 0);
            tick();
            check_eq("hold_ex_rd", ex_rd_addr, 9);
            check_eq("hold_ex_pc", ex_pc, 32'h80);
            check_eq("hold_ex_imm", ex_immediate, 32'h10);
            check_eq("hold_ex_valid", ex_valid, 1);
            check_eq("hold_stall_count", stall_count, 1);
        end
        ex_hold = 1'b0;
        settle();
        check_eq("unhold_hazard", hazard_mux_enable, 1);
        tick();
        check_eq("unhold_stall_count", stall_count, 2);
        check_eq("unhold_bubble", ex_valid, 0);

        // Saturation: fresh reset, five load-use stalls, 2-bit counter stops at 3.
        rst = 1'b1;
        id_clear();
        tick();
        rst = 1'b0;
        check_eq("sat_rst_count", s_stall_count, 0);
        for (int i = 0; i < 5; i++) begin
            id_load(5'd5, 5'd1, 32'h200, 32'd0);
            tick();
            id_add(5'd6, 5'd5, 5'd7, 32'h204);
            tick();
            tick();
        end
        check_eq("sat_count_2bit", s_stall_count, 3);
        check_eq("sat_count_16bit", stall_count, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
